// File: rtl/mem_arbiter_pkg.sv
// Shared types and bus widths for the packet-buffer memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int WIDTH_W = 4;

  // Arbiter FSM: either nobody owns the mem port, or exactly one client does.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side and mem-side buses of the arbiter bundled into one interface.
//
// Handshake: a client raises req_i[k] and holds it until done. gnt_o[k] (registered)
// says it owns the port. While owning, each cycle with ce_i[k]=1 (and req_i[k]=1) issues
// one access to mem, and ack_o[k] pulses exactly one cycle later; for reads rdata_o is
// valid in that ack cycle. Strobes from clients without the grant are dropped, never acked.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import mem_arbiter_pkg::*;

  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ-1:0]         lock_i;
  logic [NUM_REQ-1:0]         ce_i;
  logic [NUM_REQ-1:0]         we_i;
  logic [NUM_REQ*ADDR_W-1:0]  addr_i;
  logic [NUM_REQ*WIDTH_W-1:0] width_i;
  logic [NUM_REQ*DATA_W-1:0]  wdata_i;
  logic [NUM_REQ-1:0]         gnt_o;
  logic [NUM_REQ-1:0]         ack_o;
  logic [DATA_W-1:0]          rdata_o;
  logic                       mem_ce_o;
  logic                       mem_we_o;
  logic [ADDR_W-1:0]          mem_addr_o;
  logic [WIDTH_W-1:0]         mem_width_o;
  logic [DATA_W-1:0]          mem_data_o;
  logic [DATA_W-1:0]          mem_data_i;

  // Arbiter view.
  modport slave (
    input  req_i, lock_i, ce_i, we_i, addr_i, width_i, wdata_i, mem_data_i,
    output gnt_o, ack_o, rdata_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
  );

  // Clients plus memory view.
  modport master (
    output req_i, lock_i, ce_i, we_i, addr_i, width_i, wdata_i, mem_data_i,
    input  gnt_o, ack_o, rdata_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after rr_ptr_i, wrapping.
module mem_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ; the last slot is the previous winner itself.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o      = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single mem/sram port between NUM_REQ packet-buffer clients with
// round-robin grant, optional burst lock and a bounded hold for fairness.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,      // asynchronous, active low
  mem_arbiter_if.slave  bus,
  output arb_state_t    state_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  // rr_ptr doubles as the owner index while in ARB_OWN (it is set to the winner).
  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                own_req, own_lock, own_ce, own_we;
  logic [ADDR_W-1:0]   own_addr;
  logic [WIDTH_W-1:0]  own_width;
  logic [DATA_W-1:0]   own_wdata;
  logic                issue;
  logic                others_req;
  logic                release_now;

  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  mem_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (bus.req_i),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Select the current owner's client signals.
  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_ce    = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_width = '0;
    own_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_ptr_q == IDX_W'(k)) begin
        own_req   = bus.req_i[k];
        own_lock  = bus.lock_i[k];
        own_ce    = bus.ce_i[k];
        own_we    = bus.we_i[k];
        own_addr  = bus.addr_i[k*ADDR_W +: ADDR_W];
        own_width = bus.width_i[k*WIDTH_W +: WIDTH_W];
        own_wdata = bus.wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Route the owner to mem; an owner that dropped req_i issues nothing.
  always_comb begin
    issue       = (state_q == ARB_OWN) && own_req && own_ce;
    others_req  = |(bus.req_i & ~gnt_q);
    release_now = !own_req ||
                  (!own_lock && (hold_q == HOLD_W'(MAX_HOLD)) && others_req);
    bus.mem_ce_o    = issue;
    bus.mem_we_o    = issue && own_we;
    bus.mem_addr_o  = '0;
    bus.mem_width_o = '0;
    bus.mem_data_o  = '0;
    if (state_q == ARB_OWN) begin
      bus.mem_addr_o  = own_addr;
      bus.mem_width_o = own_width;
      bus.mem_data_o  = own_wdata;
    end
  end

  // Next-state: grant/release decisions, hold counting, ack and read-data capture.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    rdata_d  = rdata_q;
    ack_d    = '0;

    // An issued access is acked next cycle even if the grant is released now.
    if (issue) begin
      ack_d[rr_ptr_q] = 1'b1;
      if (!own_we) rdata_d = bus.mem_data_i;
      if (hold_q != HOLD_W'(MAX_HOLD)) hold_d = hold_q + HOLD_W'(1);
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d  = ARB_OWN;
          gnt_d    = pick;
          rr_ptr_d = pick_idx;
          hold_d   = '0;
        end
      end
      ARB_OWN: begin
        if (release_now) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; reset clears grant and any owed ack immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      hold_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural sram behind the arbiter, directed table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(NREQ)) bus();
  arb_state_t state_dbg;

  mem_arbiter #(.NUM_REQ(NREQ), .MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  function automatic logic [31:0] pkt_word(input int i);
    return 32'h5A00C0DE ^ (32'(i) * 32'h00010203);
  endfunction

  // Behavioural sram: combinational read, byte-masked synchronous write.
  logic [31:0] sram [0:63];
  assign bus.mem_data_i = sram[bus.mem_addr_o[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) sram[i] <= pkt_word(i);
    end else if (bus.mem_ce_o && bus.mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_width_o[b]) sram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_owner;   // -1 = nobody
  int              m_last;    // last winner
  int              m_count;   // accesses by current owner, saturating
  logic [NREQ-1:0] m_ack;
  bit              m_rd_due;
  logic [31:0]     ref_mem [0:63];

  task automatic model_reset();
    m_owner  = -1;
    m_last   = NREQ - 1;
    m_count  = 0;
    m_ack    = '0;
    m_rd_due = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] eg;
    bit ece, ewe;
    eg  = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    ece = (m_owner >= 0) && bus.req_i[m_owner] && bus.ce_i[m_owner];
    ewe = ece && bus.we_i[m_owner];
    chk("gnt", 32'(bus.gnt_o), 32'(eg));
    chk("ack", 32'(bus.ack_o), 32'(m_ack));
    chk("state", 32'(state_dbg == ARB_OWN), 32'(m_owner >= 0));
    if (m_rd_due) begin
      if (exp_q.size() == 0) chk("rdata_queue", 32'(0), 32'(1));
      else chk("rdata", bus.rdata_o, exp_q.pop_front());
    end
    chk("mem_ce", 32'(bus.mem_ce_o), 32'(ece));
    chk("mem_we", 32'(bus.mem_we_o), 32'(ewe));
    if (ece) begin
      chk("mem_addr", bus.mem_addr_o, bus.addr_i[m_owner*32 +: 32]);
      chk("mem_width", 32'(bus.mem_width_o), 32'(bus.width_i[m_owner*4 +: 4]));
      if (ewe) chk("mem_data", bus.mem_data_o, bus.wdata_i[m_owner*32 +: 32]);
    end else if (m_owner < 0) begin
      chk("mem_addr_idle", bus.mem_addr_o, 32'(0));
    end
  endtask

  task automatic model_advance();
    logic [NREQ-1:0] nack;
    int o, a;
    bit acc;
    nack     = '0;
    m_rd_due = 1'b0;
    if (m_owner < 0) begin
      for (int i = 1; i <= NREQ; i++) begin
        o = (m_last + i) % NREQ;
        if (m_owner < 0 && bus.req_i[o]) begin
          m_owner = o;
          m_last  = o;
          m_count = 0;
        end
      end
    end else begin
      o   = m_owner;
      acc = bus.req_i[o] && bus.ce_i[o];
      if (acc) begin
        nack[o] = 1'b1;
        a = 32'(bus.addr_i[o*32 +: 32]) >> 2;
        a = a % 64;
        if (bus.we_i[o]) begin
          for (int b = 0; b < 4; b++)
            if (bus.width_i[o*4 + b]) ref_mem[a][8*b +: 8] = bus.wdata_i[o*32 + 8*b +: 8];
        end else begin
          exp_q.push_back(ref_mem[a]);
          m_rd_due = 1'b1;
        end
      end
      if (!bus.req_i[o]) m_owner = -1;
      else if (!bus.lock_i[o] && m_count == MAXH && (bus.req_i & ~NREQ'(1 << o)) != '0) m_owner = -1;
      if (acc && m_count < MAXH) m_count++;
    end
    m_ack = nack;
  endtask

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [1:0]  req, lock, ce, we;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  wd0, wd1;
    logic [1:0]  exp_gnt, exp_ack;
    logic        exp_ce;
    logic        rd_chk;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] req, ce, we, input logic [31:0] a0, a1,
                              input logic [1:0] eg, ea, input logic ece,
                              input logic rdc, input logic [31:0] erd);
    vec_t v;
    v.req = req; v.lock = 2'b00; v.ce = ce; v.we = we;
    v.a0 = a0; v.a1 = a1; v.d0 = 32'h0; v.d1 = 32'h0; v.wd0 = 4'hF; v.wd1 = 4'hF;
    v.exp_gnt = eg; v.exp_ack = ea; v.exp_ce = ece; v.rd_chk = rdc; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req_i   = v.req;
    bus.lock_i  = v.lock;
    bus.ce_i    = v.ce;
    bus.we_i    = v.we;
    bus.addr_i  = {v.a1, v.a0};
    bus.wdata_i = {v.d1, v.d0};
    bus.width_i = {v.wd1, v.wd0};
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_tbl(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("tbl%0d_gnt", idx), 32'(bus.gnt_o), 32'(v.exp_gnt));
    chk($sformatf("tbl%0d_ack", idx), 32'(bus.ack_o), 32'(v.exp_ack));
    chk($sformatf("tbl%0d_mem_ce", idx), 32'(bus.mem_ce_o), 32'(v.exp_ce));
    if (v.rd_chk) chk($sformatf("tbl%0d_rdata", idx), bus.rdata_o, v.exp_rdata);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge: hold reset one cycle, check, release.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt_o), 32'(0));
    chk("rst_ack", 32'(bus.ack_o), 32'(0));
    chk("rst_mem_ce", 32'(bus.mem_ce_o), 32'(0));
    chk("rst_rdata", bus.rdata_o, 32'(0));
    chk("rst_state", 32'(state_dbg), 32'(ARB_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [9];
  vec_t v;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks, lost;
    bit seen, dropped;
    rst     = 1'b0;
    preload = 1'b1;
    v = mk(2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    drive(v);
    for (int i = 0; i < 64; i++) ref_mem[i] = pkt_word(i);
    @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset with both requesting; client 0 must win the first edge after release.
    do_reset();
    tick();
    chk("first_gnt_c0", 32'(bus.gnt_o), 32'(2'b01));

    // Directed table: back-to-back reads, release, ignored non-owner strobes.
    tbl[0] = mk(2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    tbl[1] = mk(2'b01, 2'b01, 2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    tbl[2] = mk(2'b01, 2'b01, 2'b00, 32'h4, 32'h0, 2'b01, 2'b01, 1'b1, 1'b1, pkt_word(0));
    tbl[3] = mk(2'b01, 2'b00, 2'b00, 32'h4, 32'h0, 2'b01, 2'b01, 1'b0, 1'b1, pkt_word(1));
    tbl[4] = mk(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
    tbl[5] = mk(2'b10, 2'b00, 2'b00, 32'h0, 32'h8, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    tbl[6] = mk(2'b10, 2'b11, 2'b01, 32'h0, 32'h8, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0);
    tbl[7] = mk(2'b00, 2'b11, 2'b00, 32'h0, 32'h8, 2'b10, 2'b10, 1'b0, 1'b1, pkt_word(2));
    tbl[8] = mk(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      tick_tbl(tbl[i], i);
    end

    // Bounded hold: unlocked client 0 streaming while client 1 waits.
    do_reset();
    v = mk(2'b11, 2'b01, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    drive(v);
    acks = 0; seen = 1'b0; dropped = 1'b0;
    for (int c = 0; c < 30 && !dropped; c++) begin
      bus.addr_i[31:0] = 32'((c % 16) * 4);
      tick();
      if (bus.gnt_o == 2'b01) begin
        seen = 1'b1;
        if (bus.ack_o[0]) acks++;
      end else if (seen) begin
        dropped = 1'b1;
        chk("hold_owed_ack", 32'(bus.ack_o), 32'(2'b01));
      end
    end
    chk("hold_released", 32'(dropped), 32'(1));
    chk("hold_acks", 32'(acks), 32'(MAXH));
    tick();
    chk("handover_gnt_c1", 32'(bus.gnt_o), 32'(2'b10));

    // Locked burst: client 0 keeps the port until it drops req.
    do_reset();
    v = mk(2'b11, 2'b01, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    v.lock = 2'b01;
    drive(v);
    tick();
    lost = 0;
    for (int c = 0; c < 20; c++) begin
      bus.addr_i[31:0] = 32'((c % 16) * 4);
      tick();
      if (bus.gnt_o != 2'b01) lost++;
    end
    chk("lock_no_release", 32'(lost), 32'(0));
    bus.req_i = 2'b10;
    tick();
    chk("lock_drop_gnt", 32'(bus.gnt_o), 32'(0));
    tick();
    chk("lock_next_c1", 32'(bus.gnt_o), 32'(2'b10));

    // Write by client 1, read back by client 0.
    do_reset();
    v = mk(2'b10, 2'b10, 2'b10, 32'h10, 32'h10, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    v.d1 = 32'hDEADBEEF;
    drive(v);
    tick();
    tick();
    chk("wr_ack_c1", 32'(bus.ack_o), 32'(2'b10));
    bus.req_i = 2'b00; bus.ce_i = 2'b00; bus.we_i = 2'b00;
    tick();
    bus.req_i = 2'b01;
    tick();
    bus.ce_i = 2'b01;
    tick();
    chk("rd_back_ack", 32'(bus.ack_o), 32'(2'b01));
    chk("rd_back_data", bus.rdata_o, 32'hDEADBEEF);
    bus.req_i = 2'b00; bus.ce_i = 2'b00;
    tick();

    // Reset right after an owner's access: owed ack dropped, grant cleared at once.
    do_reset();
    v = mk(2'b10, 2'b10, 2'b00, 32'h0, 32'h8, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    drive(v);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.ack_o), 32'(0));
    chk("midrst_gnt", 32'(bus.gnt_o), 32'(0));
    bus.req_i = 2'b11; bus.ce_i = 2'b00;
    do_reset();
    tick();
    chk("midrst_restart_c0", 32'(bus.gnt_o), 32'(2'b01));

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 7) == 0) bus.req_i[k] = ~bus.req_i[k];
        if ($urandom_range(0, 15) == 0) bus.lock_i[k] = ~bus.lock_i[k];
        bus.ce_i[k]             = ($urandom_range(0, 3) != 0);
        bus.we_i[k]             = ($urandom_range(0, 2) == 0);
        bus.addr_i[k*32 +: 32]  = 32'($urandom_range(0, 15)) << 2;
        bus.width_i[k*4 +: 4]   = 4'($urandom_range(1, 15));
        bus.wdata_i[k*32 +: 32] = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
